// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter with burst hold.
package rr_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Width of an index able to address n requesters.
  function automatic int rr_idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating priority picker: finds the first set request bit
// at or after the start index, wrapping past the top back to bit 0.
module rr_priority_picker
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]              requests,
  input  logic [rr_idx_w(N_REQ)-1:0]    start,
  output logic [N_REQ-1:0]              onehot,
  output logic [rr_idx_w(N_REQ)-1:0]    idx,
  output logic                          valid
);

  localparam int IDX_W = rr_idx_w(N_REQ);

  int pos;

  // Scan from the far end back toward start so the nearest hit wins last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = (int'(start) + k) % N_REQ;
      if (requests[pos]) begin
        onehot      = '0;
        onehot[pos] = 1'b1;
        idx         = IDX_W'(pos);
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter_with_burst_hold.sv
// N-requester round-robin arbiter with bounded burst hold.
// A granted requester keeps the grant while it keeps requesting, for at most
// MAX_BURST consecutive cycles; then priority rotates past it.
// Optional build macro RR_ARB_REGISTERED_GRANT_EN registers all outputs,
// adding one cycle of latency without changing the arbitration state.
module round_robin_arbiter_with_burst_hold
  import rr_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             requests,
  output logic [N_REQ-1:0]             grants,
  output logic                         grant_valid,
  output logic [rr_idx_w(N_REQ)-1:0]   grant_idx,
  output logic                         burst_last
);

  localparam int IDX_W = rr_idx_w(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] last, last_nxt;
  logic [CNT_W-1:0] count, count_nxt;

  logic             hold;
  logic [IDX_W-1:0] start;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  logic [N_REQ-1:0] dec_grants;
  logic [IDX_W-1:0] dec_idx;
  logic             dec_valid;
  logic             dec_last;

  rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .requests (requests),
    .start    (start),
    .onehot   (pick_onehot),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  // Scan start is the requester just after the most recent winner.
  always_comb begin
    start = (last == IDX_W'(N_REQ - 1)) ? '0 : last + IDX_W'(1);
  end

  // Grant decision and next-state: hold the owner, else re-arbitrate.
  always_comb begin
    hold       = (state == ARB_BUSY) && requests[owner] &&
                 (count < CNT_W'(MAX_BURST));
    dec_grants = '0;
    dec_idx    = '0;
    dec_valid  = 1'b0;
    dec_last   = 1'b0;
    state_nxt  = ARB_IDLE;
    owner_nxt  = owner;
    last_nxt   = last;
    count_nxt  = '0;

    if (hold) begin
      dec_grants = N_REQ'(1) << owner;
      dec_idx    = owner;
      dec_valid  = 1'b1;
      dec_last   = (count == CNT_W'(MAX_BURST - 1));
    end else if (pick_valid) begin
      dec_grants = pick_onehot;
      dec_idx    = pick_idx;
      dec_valid  = 1'b1;
      dec_last   = (MAX_BURST == 1);
    end

    if (dec_valid) begin
      state_nxt = ARB_BUSY;
      owner_nxt = dec_idx;
      last_nxt  = dec_idx;
      count_nxt = hold ? count + CNT_W'(1) : CNT_W'(1);
    end
  end

  // Arbitration state register; reset gives requester 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= '0;
      last  <= IDX_W'(N_REQ - 1);
      count <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      count <= count_nxt;
    end
  end

`ifdef RR_ARB_REGISTERED_GRANT_EN
  // Registered copy of the decision: outputs lag the decision by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grants      <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      burst_last  <= 1'b0;
    end else begin
      grants      <= dec_grants;
      grant_valid <= dec_valid;
      grant_idx   <= dec_idx;
      burst_last  <= dec_last;
    end
  end
`else
  // Zero-latency outputs, forced quiet while reset is held.
  always_comb begin
    grants      = rst ? '0   : dec_grants;
    grant_valid = rst ? 1'b0 : dec_valid;
    grant_idx   = rst ? '0   : dec_idx;
    burst_last  = rst ? 1'b0 : dec_last;
  end
`endif

endmodule

// File: tb/tb_round_robin_arbiter_with_burst_hold.sv
// Self-checking bench for round_robin_arbiter_with_burst_hold (N_REQ=4,
// MAX_BURST=3). Honours RR_ARB_REGISTERED_GRANT_EN when defined.
`timescale 1ns/1ps
module tb_round_robin_arbiter_with_burst_hold;

  localparam int N_REQ     = 4;
  localparam int MAX_BURST = 3;
  localparam int IDX_W     = $clog2(N_REQ);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_REQ-1:0] requests = '0;
  logic [N_REQ-1:0] grants;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             burst_last;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: who holds the rotation pointer, who owns the current
  // burst and how many grants that burst has already had.
  int m_last, m_owner, m_run;
  bit m_busy;
  // Decision for the current cycle.
  int d_win;
  bit d_last;
  // Expected registered outputs (registered build only).
  int r_win;
  bit r_last;

  int obs_idx;
  int obs_bl;

  round_robin_arbiter_with_burst_hold #(
    .N_REQ     (N_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .requests    (requests),
    .grants      (grants),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .burst_last  (burst_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, required %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = N_REQ - 1;
    m_owner = 0;
    m_run   = 0;
    m_busy  = 0;
    r_win   = -1;
    r_last  = 0;
  endtask

  // Winner: the current owner while its burst has room and it still asks;
  // otherwise the first asker after the last winner going round the ring.
  // burst_last means this grant is the one that fills a MAX_BURST burst.
  task automatic model_decide(input logic [N_REQ-1:0] r);
    int new_run;
    d_win   = -1;
    new_run = 0;
    if (m_busy && r[m_owner] && m_run < MAX_BURST) begin
      d_win   = m_owner;
      new_run = m_run + 1;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (d_win < 0 && r[(m_last + k) % N_REQ]) d_win = (m_last + k) % N_REQ;
      end
      new_run = 1;
    end
    d_last = (d_win >= 0) && (new_run == MAX_BURST);
  endtask

  task automatic model_commit();
    if (d_win >= 0) begin
      if (m_busy && d_win == m_owner && m_run < MAX_BURST && d_win == m_last && requests[m_owner])
        m_run = m_run + 1;
      else
        m_run = 1;
      m_owner = d_win;
      m_last  = d_win;
      m_busy  = 1;
    end else begin
      m_busy = 0;
      m_run  = 0;
    end
  endtask

  // One cycle: drive at negedge, check settled outputs, advance at posedge.
  task automatic step(input logic rst_v, input logic [N_REQ-1:0] r);
    int ew;
    bit el;
    @(negedge clk);
    rst      = rst_v;
    requests = r;
    if (rst_v) model_reset();
    #1;
    if (rst_v) begin
      d_win  = -1;
      d_last = 0;
    end else begin
      model_decide(r);
    end
`ifdef RR_ARB_REGISTERED_GRANT_EN
    ew = r_win;
    el = r_last;
`else
    ew = d_win;
    el = d_last;
`endif
    check("grants",      32'(grants),      (ew >= 0) ? (32'd1 << ew) : 32'd0);
    check("grant_valid", 32'(grant_valid), 32'(ew >= 0));
    check("grant_idx",   32'(grant_idx),   (ew >= 0) ? 32'(ew) : 32'd0);
    check("burst_last",  32'(burst_last),  32'(el));
    obs_idx = grant_valid ? int'(grant_idx) : -1;
    obs_bl  = int'(burst_last);
    @(posedge clk);
    cyc++;
    if (!rst_v) begin
      model_commit();
      r_win  = d_win;
      r_last = d_last;
    end
  endtask

  int t1_idx [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int t2_bl  [7]  = '{0, 0, 1, 0, 0, 1, 0};
  logic [N_REQ-1:0] rnd_req;

  initial begin
    model_reset();

    // Reset held: outputs quiet whatever the requests.
    step(1'b1, 4'b1111);
    step(1'b1, 4'b0101);

    // Full contention: bursts of three rotating through all requesters.
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 4'b1111);
`ifndef RR_ARB_REGISTERED_GRANT_EN
      check("t1_idx", 32'(obs_idx), 32'(t1_idx[i]));
      check("t1_last", 32'(obs_bl), 32'(i % 3 == 2));
`endif
    end

    // Lone requester: re-granted back to back across burst boundaries.
    step(1'b1, 4'b0000);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 4'b0001);
`ifndef RR_ARB_REGISTERED_GRANT_EN
      check("t2_idx", 32'(obs_idx), 32'd0);
      check("t2_last", 32'(obs_bl), 32'(t2_bl[i]));
`endif
    end

    // Owner drops mid-burst: next requester granted in the same cycle.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0011);
    step(1'b0, 4'b0010);
`ifndef RR_ARB_REGISTERED_GRANT_EN
    check("t3_idx", 32'(obs_idx), 32'd1);
`endif

    // Idle gap then rotation resumes after the last winner.
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0101);
`ifndef RR_ARB_REGISTERED_GRANT_EN
    check("t4_idx", 32'(obs_idx), 32'd0);
`endif
    step(1'b0, 4'b0000);

    // Reset in the middle of a burst; burst is not resumed.
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    step(1'b1, 4'b0100);
    step(1'b0, 4'b1111);
`ifndef RR_ARB_REGISTERED_GRANT_EN
    check("t5_idx", 32'(obs_idx), 32'd0);
`endif

    // Randomised traffic with sticky requests and occasional resets.
    rnd_req = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = N_REQ'($urandom);
      if ($urandom_range(0, 9) == 0) rnd_req[$urandom_range(0, N_REQ-1)] = 1'b0;
      step(($urandom_range(0, 63) == 0), rnd_req);
    end
    step(1'b0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
